hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It sits beside the ID-stage forwarding unit and decides when the PC and the IF/ID register hold, when bubbles go into ID/EXE, and when wrong-path instructions are flushed. It also sequences the multi-cycle multiply/divide unit (MDU) with a busy counter and keeps a free-running stall-cycle counter for performance measurement.

## Interface
- MDU_LAT, 32, cycles the MDU needs per operation (≥1); internal counter width is clog2(MDU_LAT+1).

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rs_id, rt_id  in  5  source register numbers of the ID instruction
- use_rs_id, use_rt_id  in  1  ID instruction actually reads rs / rt
- rd_exe  in  5  destination register of the EXE instruction
- RegWrite_exe  in  1  EXE instruction writes a register
- MemRead_exe  in  3  EXE load type; nonzero means load
- branch_taken_id  in  1  branch/jump in ID resolved taken
- mdu_start_exe  in  1  EXE instruction launches an MDU operation
- mdu_use_id  in  1  ID instruction is an MDU op or mfhi/mflo
- exc_flush  in  1  exception or eret redirect from MEM
- stall_pc  out  1  hold PC
- stall_ifid  out  1  hold IF/ID
- flush_ifid  out  1  clear IF/ID to nop
- flush_idexe  out  1  insert bubble in ID/EXE
- flush_exemem  out  1  clear EXE/MEM
- mdu_busy  out  1  MDU operation in progress
- mdu_done  out  1  one-cycle pulse, MDU result valid in HI/LO
- stall_cnt  out  32  count of cycles with stall_pc=1

## Operation
- FSM states: RUN, MDU_BUSY. Counter cnt.
- RUN: mdu_start_exe=1 at edge (and exc_flush=0) → MDU_BUSY, cnt←MDU_LAT.
- MDU_BUSY: cnt decrements each edge; cnt==1 at edge → RUN, cnt←0, mdu_done←1 for the next cycle only. mdu_start_exe in MDU_BUSY is ignored.
- mdu_busy = (state==MDU_BUSY); high for exactly MDU_LAT cycles per operation.
- Hazard terms (combinational):
  - load_use = MemRead_exe≠0 & RegWrite_exe & rd_exe≠0 & ((use_rs_id & rd_exe==rs_id) | (use_rt_id & rd_exe==rt_id)).
  - mdu_hz = mdu_use_id & (mdu_busy | mdu_start_exe).
- Priority, highest first:
  1. exc_flush: flush_ifid=flush_idexe=flush_exemem=1, all stalls 0. FSM forced to RUN, cnt←0, no mdu_done pulse.
  2. mdu_hz: stall_pc=stall_ifid=flush_idexe=1.
  3. load_use: same as mdu_hz, one cycle per occurrence. A branch depending on a load stalls once, then takes the forwarded MEM load value.
  4. branch_taken_id and no stall: flush_ifid=1.
- branch_taken_id is ignored in any cycle where stall_pc=1, because operands are not yet valid.
- Non-listed outputs are 0. Register $0 never causes a hazard.
- stall_cnt increments at each edge where stall_pc=1 and wraps 0xFFFFFFFF→0.

## Timing
- Reset (async, immediate): state RUN, cnt 0, mdu_done 0, stall_cnt 0. While rst=1, all combinational outputs are forced to 0.
- Stall and flush outputs are combinational, same cycle as the inputs, and must settle before the pipeline register edge.
- mdu_busy rises the cycle after the start edge and falls MDU_LAT cycles later. mdu_done coincides with the first RUN cycle.
- MDU_LAT=1: one busy cycle, then done.
- exc_flush asserted mid-MDU aborts the operation. mdu_busy=0 and no done pulse from the next edge on.
- Simultaneous mdu_start_exe and exc_flush: the start is discarded.
- Simultaneous load_use and mdu_hz: a single stall results, and the outputs are identical.

## Test plan
- lw $8 in EXE (MemRead_exe=3'b001, rd_exe=8), ID reads rs=8 → stall_pc=stall_ifid=flush_idexe=1 for 1 cycle, stall_cnt +1. Repeat with rd_exe=0 → no stall.
- MDU_LAT=4, mdu_start_exe pulse, mfhi in ID → mdu_busy high 4 cycles, stall for 5 cycles (start cycle + 4), mdu_done high on cycle 5 only, stall_cnt=5.
- branch_taken_id=1 with no hazard → flush_ifid=1 only. Same with load_use=1 → branch ignored, stall outputs only.
- exc_flush on busy cycle 2 of 4 → all three flushes=1, next cycle mdu_busy=0, no mdu_done ever.
- Assert rst mid-MDU and with stall_cnt=0x10 → outputs 0 immediately, state RUN, stall_cnt=0. Preload stall_cnt near 0xFFFFFFFF and run 2 stall cycles → wraps to 1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the five-stage MIPS core.
// Resolves load-use, MDU-busy, branch and exception redirects, and sequences the MDU.
module hazard_ctrl #(
    parameter int unsigned MDU_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic [4:0]  rd_exe,
    input  logic        RegWrite_exe,
    input  logic [2:0]  MemRead_exe,
    input  logic        branch_taken_id,
    input  logic        mdu_start_exe,
    input  logic        mdu_use_id,
    input  logic        exc_flush,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        flush_ifid,
    output logic        flush_idexe,
    output logic        flush_exemem,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_cnt
);

    localparam int CW = $clog2(MDU_LAT + 1);

    typedef enum logic {
        RUN,
        MDU_BUSY
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           done_q;
    logic [31:0]    stall_cnt_q;
    logic [31:0]    stall_cnt_d;

    logic load_use;
    logic mdu_hz;

    // Register $0 is hard-wired to zero, so it can never be a real dependency.
    assign load_use = (MemRead_exe != 3'd0) && RegWrite_exe && (rd_exe != 5'd0) &&
                      ((use_rs_id && (rd_exe == rs_id)) || (use_rt_id && (rd_exe == rt_id)));

    assign mdu_busy = (state_q == MDU_BUSY);
    assign mdu_hz   = mdu_use_id && (mdu_busy || mdu_start_exe);
    assign mdu_done = done_q;

    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        flush_ifid   = 1'b0;
        flush_idexe  = 1'b0;
        flush_exemem = 1'b0;
        if (!rst) begin
            if (exc_flush) begin
                flush_ifid   = 1'b1;
                flush_idexe  = 1'b1;
                flush_exemem = 1'b1;
            end else if (mdu_hz || load_use) begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                flush_idexe = 1'b1;
            end else if (branch_taken_id) begin
                flush_ifid = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (exc_flush) begin
                state_q <= RUN;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (mdu_start_exe) begin
                            state_q <= MDU_BUSY;
                            cnt_q   <= CW'(MDU_LAT);
                        end
                    end
                    MDU_BUSY: begin
                        if (cnt_q == CW'(1)) begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign stall_cnt_d = stall_pc ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, MDU/exception/reset sequences,
// and randomized stimulus against a behavioural model of the stall/flush rules.
module tb_hazard_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_id, rt_id, rd_exe;
    logic        use_rs_id, use_rt_id, RegWrite_exe;
    logic [2:0]  MemRead_exe;
    logic        branch_taken_id, mdu_start_exe, mdu_use_id, exc_flush;

    logic        stall_pc, stall_ifid, flush_ifid, flush_idexe, flush_exemem;
    logic        mdu_busy, mdu_done;
    logic [31:0] stall_cnt;

    logic        stall_pc1, stall_ifid1, flush_ifid1, flush_idexe1, flush_exemem1;
    logic        mdu_busy1, mdu_done1;
    logic [31:0] stall_cnt1;

    hazard_ctrl #(.MDU_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .rd_exe(rd_exe),
        .RegWrite_exe(RegWrite_exe), .MemRead_exe(MemRead_exe),
        .branch_taken_id(branch_taken_id), .mdu_start_exe(mdu_start_exe),
        .mdu_use_id(mdu_use_id), .exc_flush(exc_flush),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
        .flush_idexe(flush_idexe), .flush_exemem(flush_exemem),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.MDU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .rd_exe(rd_exe),
        .RegWrite_exe(RegWrite_exe), .MemRead_exe(MemRead_exe),
        .branch_taken_id(branch_taken_id), .mdu_start_exe(mdu_start_exe),
        .mdu_use_id(mdu_use_id), .exc_flush(exc_flush),
        .stall_pc(stall_pc1), .stall_ifid(stall_ifid1), .flush_ifid(flush_ifid1),
        .flush_idexe(flush_idexe1), .flush_exemem(flush_exemem1),
        .mdu_busy(mdu_busy1), .mdu_done(mdu_done1), .stall_cnt(stall_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] rd;
        logic       regw;
        logic [2:0] memrd;
        logic       br;
        logic       start;
        logic       muse;
        logic       exc;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [4:0] exp;   // {stall_pc, stall_ifid, flush_ifid, flush_idexe, flush_exemem}
    } vec_t;

    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_STALL = 5'b11010;
    localparam logic [4:0] O_BR    = 5'b00100;
    localparam logic [4:0] O_EXC   = 5'b00111;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] exp_cnt;
    logic [31:0] exp_cnt1;

    // Behavioural model state: remaining busy cycles, pending done pulse, stall tally.
    int          m_rem;
    bit          m_done;
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt,
                               input logic use_rs, input logic use_rt,
                               input logic [4:0] rd, input logic regw,
                               input logic [2:0] memrd, input logic br,
                               input logic start, input logic muse, input logic exc);
        in_t v;
        v.rs = rs; v.rt = rt; v.use_rs = use_rs; v.use_rt = use_rt; v.rd = rd;
        v.regw = regw; v.memrd = memrd; v.br = br; v.start = start; v.muse = muse;
        v.exc = exc;
        return v;
    endfunction

    function automatic logic [4:0] outs();
        return {stall_pc, stall_ifid, flush_ifid, flush_idexe, flush_exemem};
    endfunction

    function automatic logic [4:0] outs1();
        return {stall_pc1, stall_ifid1, flush_ifid1, flush_idexe1, flush_exemem1};
    endfunction

    task automatic apply(input in_t v);
        rs_id = v.rs; rt_id = v.rt; use_rs_id = v.use_rs; use_rt_id = v.use_rt;
        rd_exe = v.rd; RegWrite_exe = v.regw; MemRead_exe = v.memrd;
        branch_taken_id = v.br; mdu_start_exe = v.start; mdu_use_id = v.muse;
        exc_flush = v.exc;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input in_t v);
        @(negedge clk);
        apply(v);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply('0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Expected stall/flush vector straight from the priority rules.
    function automatic logic [4:0] ref_comb(input in_t v, input bit busy);
        bit lu, mh;
        lu = (v.memrd != 3'd0) && v.regw && (v.rd != 5'd0) &&
             ((v.use_rs && v.rd == v.rs) || (v.use_rt && v.rd == v.rt));
        mh = v.muse && (busy || v.start);
        if (v.exc) return O_EXC;
        if (lu || mh) return O_STALL;
        if (v.br) return O_BR;
        return O_NONE;
    endfunction

    task automatic model_edge(input in_t v, input logic [4:0] comb);
        m_done = 1'b0;
        if (v.exc) begin
            m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
        end else if (v.start) begin
            m_rem = LAT;
        end
        if (comb[4]) m_cnt = m_cnt + 32'd1;
    endtask

    vec_t vecs[12];
    in_t  lu_v;
    in_t  idle_v;

    initial begin
        in_t         v;
        logic [4:0]  e;
        idle_v = '0;
        lu_v   = mk(5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);

        vecs[0]  = '{"lw_rs_hit",     lu_v, O_STALL};
        vecs[1]  = '{"rd_zero",       mk(0, 0, 1, 0, 0, 1, 3'b001, 0, 0, 0, 0), O_NONE};
        vecs[2]  = '{"lw_rt_hit",     mk(3, 9, 1, 1, 9, 1, 3'b001, 0, 0, 0, 0), O_STALL};
        vecs[3]  = '{"rt_unused",     mk(3, 9, 1, 0, 9, 1, 3'b001, 0, 0, 0, 0), O_NONE};
        vecs[4]  = '{"alu_not_load",  mk(8, 0, 1, 0, 8, 1, 3'b000, 0, 0, 0, 0), O_NONE};
        vecs[5]  = '{"no_regwrite",   mk(8, 0, 1, 0, 8, 0, 3'b001, 0, 0, 0, 0), O_NONE};
        vecs[6]  = '{"branch_only",   mk(1, 2, 1, 1, 5, 1, 3'b001, 1, 0, 0, 0), O_BR};
        vecs[7]  = '{"branch_on_lu",  mk(8, 2, 1, 1, 8, 1, 3'b001, 1, 0, 0, 0), O_STALL};
        vecs[8]  = '{"exc_only",      mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1), O_EXC};
        vecs[9]  = '{"exc_over_lu",   mk(8, 0, 1, 0, 8, 1, 3'b001, 1, 0, 1, 1), O_EXC};
        vecs[10] = '{"muse_idle_mdu", mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0), O_NONE};
        vecs[11] = '{"lhu_rs_hit",    mk(31, 0, 1, 0, 31, 1, 3'b100, 0, 0, 0, 0), O_STALL};

        // Reset state, outputs forced low even with a load-use pattern present.
        apply(lu_v);
        rst = 1'b1;
        #1;
        check("reset_comb", 32'(outs()), 32'(O_NONE));
        check("reset_busy", 32'(mdu_busy), 32'd0);
        check("reset_done", 32'(mdu_done), 32'd0);
        check("reset_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(idle_v);

        exp_cnt = 32'd0;
        foreach (vecs[i]) begin
            drive(vecs[i].in);
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
            if (vecs[i].exp[4]) exp_cnt = exp_cnt + 32'd1;
        end
        drive(idle_v);
        check("table_stall_cnt", stall_cnt, exp_cnt);
        exp_cnt1 = exp_cnt;

        // MDU op with mfhi waiting in ID: 5 stall cycles, done on cycle 5.
        for (int i = 0; i < 7; i++) begin
            v = idle_v;
            v.start = (i == 0);
            v.muse  = (i <= 5);
            drive(v);
            e = (i <= 4) ? O_STALL : O_NONE;
            check($sformatf("mdu_stall_c%0d", i), 32'(outs()), 32'(e));
            check($sformatf("mdu_busy_c%0d", i), 32'(mdu_busy), 32'((i >= 1 && i <= 4)));
            check($sformatf("mdu_done_c%0d", i), 32'(mdu_done), 32'((i == 5)));
            check($sformatf("lat1_busy_c%0d", i), 32'(mdu_busy1), 32'((i == 1)));
            check($sformatf("lat1_done_c%0d", i), 32'(mdu_done1), 32'((i == 2)));
            if (i <= 4) exp_cnt = exp_cnt + 32'd1;
            if (i <= 1) exp_cnt1 = exp_cnt1 + 32'd1;
        end
        check("mdu_stall_cnt", stall_cnt, exp_cnt);
        check("lat1_stall_cnt", stall_cnt1, exp_cnt1);
        check("lat1_comb_idle", 32'(outs1()), 32'(O_NONE));

        // Exception on busy cycle 2 aborts the operation: no done ever.
        for (int i = 0; i < 8; i++) begin
            v = idle_v;
            v.start = (i == 0);
            v.exc   = (i == 2);
            drive(v);
            if (i == 2) check("exc_mid_flush", 32'(outs()), 32'(O_EXC));
            check($sformatf("exc_busy_c%0d", i), 32'(mdu_busy), 32'((i == 1 || i == 2)));
            check($sformatf("exc_done_c%0d", i), 32'(mdu_done), 32'd0);
        end

        // Start together with exception is discarded.
        for (int i = 0; i < 6; i++) begin
            v = idle_v;
            v.start = (i == 0);
            v.exc   = (i == 0);
            drive(v);
            check($sformatf("startexc_busy_c%0d", i), 32'(mdu_busy), 32'd0);
            check($sformatf("startexc_done_c%0d", i), 32'(mdu_done), 32'd0);
        end

        // Further starts while busy are ignored; exactly LAT busy cycles.
        for (int i = 0; i < 8; i++) begin
            v = idle_v;
            v.start = (i == 0 || i == 2 || i == 4);
            drive(v);
            check($sformatf("rebusy_c%0d", i), 32'(mdu_busy), 32'((i >= 1 && i <= 4)));
            check($sformatf("redone_c%0d", i), 32'(mdu_done), 32'((i == 5)));
        end

        // Load-use and MDU hazard together give the single ordinary stall.
        v = lu_v;
        v.start = 1'b1;
        v.muse  = 1'b1;
        drive(v);
        check("lu_and_mdu", 32'(outs()), 32'(O_STALL));
        exp_cnt = exp_cnt + 32'd1;
        drive(idle_v);
        check("lu_and_mdu_cnt", stall_cnt, exp_cnt);
        repeat (6) drive(idle_v);

        // Reset mid-MDU with stall_cnt at 0x10.
        do_reset();
        for (int i = 0; i < 16; i++) drive(lu_v);
        v = idle_v;
        v.start = 1'b1;
        drive(v);
        drive(idle_v);
        check("pre_rst_busy", 32'(mdu_busy), 32'd1);
        check("pre_rst_cnt", stall_cnt, 32'h10);
        @(negedge clk);
        apply(lu_v);
        rst = 1'b1;
        #1;
        check("rst_mid_comb", 32'(outs()), 32'(O_NONE));
        check("rst_mid_busy", 32'(mdu_busy), 32'd0);
        check("rst_mid_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(idle_v);
        for (int i = 0; i < 5; i++) begin
            drive(idle_v);
            check($sformatf("post_rst_busy_c%0d", i), 32'(mdu_busy), 32'd0);
            check($sformatf("post_rst_done_c%0d", i), 32'(mdu_done), 32'd0);
        end

        // Counter wrap from a preloaded value.
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        #1;
        check("wrap_preload", stall_cnt, 32'hFFFF_FFFF);
        drive(lu_v);
        drive(lu_v);
        drive(idle_v);
        check("wrap_to_one", stall_cnt, 32'd1);

        // Randomized stimulus against the behavioural model.
        do_reset();
        m_rem  = 0;
        m_done = 1'b0;
        m_cnt  = 32'd0;
        for (int i = 0; i < 600; i++) begin
            v.rs     = 5'($urandom_range(0, 3));
            v.rt     = 5'($urandom_range(0, 3));
            v.rd     = 5'($urandom_range(0, 3));
            v.use_rs = 1'($urandom_range(0, 1));
            v.use_rt = 1'($urandom_range(0, 1));
            v.regw   = 1'($urandom_range(0, 3) != 0);
            v.memrd  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            v.br     = 1'($urandom_range(0, 3) == 0);
            v.start  = 1'($urandom_range(0, 4) == 0);
            v.muse   = 1'($urandom_range(0, 2) == 0);
            v.exc    = 1'($urandom_range(0, 19) == 0);
            drive(v);
            e = ref_comb(v, m_rem > 0);
            check("rand_comb", 32'(outs()), 32'(e));
            check("rand_busy", 32'(mdu_busy), 32'(m_rem > 0));
            check("rand_done", 32'(mdu_done), 32'(m_done));
            check("rand_cnt", stall_cnt, m_cnt);
            model_edge(v, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
